// File: rtl/pw_conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pw_conv_pkg
// Purpose  : Shared types and helpers for the pointwise convolution engine:
//            FSM state encoding, accumulator width calculation and the
//            requantisation (bias add, shift, ReLU, wrap/saturate) function.
// Config   : PW_CONV_SAT_EN - when defined, positive results above the
//            signed WIDTH-bit maximum saturate instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
package pw_conv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FINAL = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Full-precision product plus enough headroom to sum chin products.
    function automatic int acc_width(input int width, input int chin);
        return 2 * width + $clog2(chin);
    endfunction

    // Returns the activated value in the low `width` bits (upper bits zero).
    // The arithmetic shift floors toward minus infinity, so negative sums
    // always land below zero and are cleared by the ReLU.
    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input logic signed [63:0] bias,
        input int                 frac,
        input int                 width
    );
        logic signed [63:0] r;
        r = (acc + (bias <<< frac)) >>> frac;
        if (r < 64'sd0) begin
            r = 64'sd0;
        end
`ifdef PW_CONV_SAT_EN
        else if (r > ((64'sd1 <<< (width - 1)) - 64'sd1)) begin
            r = (64'sd1 <<< (width - 1)) - 64'sd1;
        end
`else
        else begin
            r = r & ((64'sd1 <<< width) - 64'sd1);
        end
`endif
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pw_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : pw_mac_lane
// Purpose  : One output-channel lane: signed multiply, load/accumulate over
//            the input channels, then bias add, shift, ReLU and wrap or
//            saturate into a registered WIDTH-bit result.
// Ports    : clk, rst (async, active-low)
//            acc_en   - accepted input beat this cycle
//            load     - beat is channel 0: load instead of add
//            capture  - register the activated result
//            act, weight, bias - signed operands
//            result   - registered activated output
// Config   : PW_CONV_SAT_EN (via pw_conv_pkg::requant)
// Revision : 1.0 - initial release
// ============================================================================
module pw_mac_lane
    import pw_conv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 2 * WIDTH + 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acc_en,
    input  logic                    load,
    input  logic                    capture,
    input  logic signed [WIDTH-1:0] act,
    input  logic signed [WIDTH-1:0] weight,
    input  logic signed [WIDTH-1:0] bias,
    output logic        [WIDTH-1:0] result
);

    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc;
    logic        [WIDTH-1:0]   act_next;

    assign product  = act * weight;
    assign prod_ext = ACC_W'(product);
    assign act_next = WIDTH'(requant(64'(acc), 64'(bias), FRAC, WIDTH));

    // Channel 0 overwrites the previous pixel's sum, so no clear cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (acc_en) begin
                acc <= load ? prod_ext : acc + prod_ext;
            end
            if (capture) begin
                result <= act_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pointwise_conv_engine.sv
`default_nettype none
// ============================================================================
// Module   : pointwise_conv_engine
// Purpose  : 1x1 convolution layer engine. CHOUT is processed as TILES
//            tiles of LANES output channels; each tile consumes the whole
//            pixel stream (tile-major, pixel, channel order) and emits one
//            activated tile per pixel. Weight/bias ROMs are external.
// Ports    : clk, rst (async, active-low), start
//            ifm_valid/ifm_ready/ifm_data - input activation stream
//            w_addr/w_data, b_addr/b_data - external ROM interface
//            ofm_valid/ofm_ready/ofm_data/ofm_tile/ofm_pixel - output tiles
//            busy, done
// Config   : PW_CONV_SAT_EN - saturate instead of wrap on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module pointwise_conv_engine
    import pw_conv_pkg::*;
#(
    parameter  int LANES  = 512,
    parameter  int WIDTH  = 16,
    parameter  int FRAC   = 8,
    parameter  int CHIN   = 736,
    parameter  int CHOUT  = 512,
    parameter  int PIXELS = 64,
    localparam int TILES  = CHOUT / LANES,
    localparam int ACC_W  = acc_width(WIDTH, CHIN),
    localparam int ADDR_W = (CHIN * TILES > 1) ? $clog2(CHIN * TILES) : 1,
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1,
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1,
    localparam int CH_W   = (CHIN > 1) ? $clog2(CHIN) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    ifm_valid,
    output logic                    ifm_ready,
    input  logic signed [WIDTH-1:0] ifm_data,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [LANES*WIDTH-1:0]  w_data,
    output logic [TILE_W-1:0]       b_addr,
    input  logic [LANES*WIDTH-1:0]  b_data,
    output logic                    ofm_valid,
    input  logic                    ofm_ready,
    output logic [LANES*WIDTH-1:0]  ofm_data,
    output logic [TILE_W-1:0]       ofm_tile,
    output logic [PIX_W-1:0]        ofm_pixel,
    output logic                    busy,
    output logic                    done
);

    if (CHOUT % LANES != 0) begin : g_bad_shape
        $fatal(1, "pointwise_conv_engine: CHOUT must be a multiple of LANES");
    end

    state_t            state;
    logic [TILE_W-1:0] tile;
    logic [PIX_W-1:0]  pixel;
    logic [CH_W-1:0]   channel;
    logic              beat;
    logic              last_ch;

    // ifm_ready is high exactly while in ACCUM, so it doubles as the
    // state qualifier for an accepted beat.
    assign beat    = ifm_valid && ifm_ready;
    assign last_ch = (channel == CH_W'(CHIN - 1));
    assign w_addr  = ADDR_W'(32'(tile) * 32'(CHIN) + 32'(channel));
    assign b_addr  = tile;

    for (genvar i = 0; i < LANES; i++) begin : g_lanes
        pw_mac_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .acc_en  (beat),
            .load    (channel == '0),
            .capture (state == ST_FINAL),
            .act     (ifm_data),
            .weight  (w_data[i*WIDTH +: WIDTH]),
            .bias    (b_data[i*WIDTH +: WIDTH]),
            .result  (ofm_data[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            tile      <= '0;
            pixel     <= '0;
            channel   <= '0;
            ifm_ready <= 1'b0;
            ofm_valid <= 1'b0;
            ofm_tile  <= '0;
            ofm_pixel <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_ACCUM;
                        tile      <= '0;
                        pixel     <= '0;
                        channel   <= '0;
                        ifm_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        if (last_ch) begin
                            channel   <= '0;
                            ifm_ready <= 1'b0;
                            state     <= ST_FINAL;
                        end else begin
                            channel <= channel + 1'b1;
                        end
                    end
                end
                ST_FINAL: begin
                    ofm_valid <= 1'b1;
                    ofm_tile  <= tile;
                    ofm_pixel <= pixel;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (ofm_ready) begin
                        ofm_valid <= 1'b0;
                        if (pixel == PIX_W'(PIXELS - 1)) begin
                            pixel <= '0;
                            if (tile == TILE_W'(TILES - 1)) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                tile      <= tile + 1'b1;
                                ifm_ready <= 1'b1;
                                state     <= ST_ACCUM;
                            end
                        end else begin
                            pixel     <= pixel + 1'b1;
                            ifm_ready <= 1'b1;
                            state     <= ST_ACCUM;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
